// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART receive packet framing controller.
package uart_pkt_pkg;

   // Framing FSM states; encodings 5..7 are illegal and fall back to S_SYNC.
   typedef enum logic [2:0] {
      S_SYNC    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CHK     = 3'd3,
      S_DRAIN   = 3'd4
   } pktState_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_CHK     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store: MAX_LEN x 8 register file, one synchronous write port and
// one combinational read port. Out-of-range addresses write nothing and read 0.
module uart_pkt_buf #(
   parameter int unsigned MAX_LEN = 16
) (
   input  logic       clk_i,
   input  logic       we_i,
   input  logic [7:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [7:0] raddr_i,
   output logic [7:0] rdata_o
);

   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [7:0] mem_q [MAX_LEN];

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk_i) begin
      if (we_i && (waddr_i < 8'(MAX_LEN))) begin
         mem_q[waddr_i[AW-1:0]] <= wdata_i;
      end
   end

   // Guarded read keeps the index inside the array for any address value.
   always_comb begin
      rdata_o = 8'h00;
      if (raddr_i < 8'(MAX_LEN)) begin
         rdata_o = mem_q[raddr_i[AW-1:0]];
      end
   end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Framing controller behind the UART receiver: hunts for SYNC, captures LEN,
// payload and XOR checksum, then drains the stored payload on a valid/ready
// stream once the checksum passes.
// Optional feature macro: UART_RX_PKT_TIMEOUT_EN adds the inter-byte timeout.
module uart_rx_pkt_ctrl
   import uart_pkt_pkg::*;
#(
   parameter int unsigned MAX_LEN      = 16,
   parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
   parameter int unsigned TIMEOUT_CLKS = 17360
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_Rx_Byte,
   input  logic       i_Rx_DV,
   output logic [7:0] o_Pkt_Data,
   output logic       o_Pkt_Valid,
   input  logic       i_Pkt_Ready,
   output logic       o_Pkt_Last,
   output logic [7:0] o_Pkt_Len,
   output logic       o_Frame_Err,
   output logic [1:0] o_Err_Code,
   output logic       o_Overrun
);

   if ((MAX_LEN < 2) || (MAX_LEN > 255) || (TIMEOUT_CLKS < 2)) begin : g_paramCheck
      $error("uart_rx_pkt_ctrl: MAX_LEN must be 2..255 and TIMEOUT_CLKS at least 2");
   end

   pktState_e  state_q, state_d;
   logic [7:0] len_q, len_d;
   logic [7:0] chk_q, chk_d;
   logic [7:0] wrIdx_q, wrIdx_d;
   logic [7:0] rdIdx_q, rdIdx_d;
   logic [7:0] pktData_q, pktData_d;
   logic       pktValid_q, pktValid_d;
   logic       pktLast_q, pktLast_d;
   logic [7:0] pktLen_q, pktLen_d;
   logic       frameErr_q, frameErr_d;
   logic [1:0] errCode_q, errCode_d;
   logic       overrun_q, overrun_d;

   logic       bufWe;
   logic [7:0] bufRaddr;
   logic [7:0] bufRdata;
   logic       toExpire;

   uart_pkt_buf #(
      .MAX_LEN (MAX_LEN)
   ) u_buf (
      .clk_i   (i_clk),
      .we_i    (bufWe),
      .waddr_i (wrIdx_q),
      .wdata_i (i_Rx_Byte),
      .raddr_i (bufRaddr),
      .rdata_o (bufRdata)
   );

`ifdef UART_RX_PKT_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS);

   logic [TO_W-1:0] toCnt_q, toCnt_d;
   logic            inFrame;

   assign inFrame  = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
   assign toExpire = inFrame && !i_Rx_DV && (toCnt_q == TO_W'(TIMEOUT_CLKS - 1));

   // Idle counter runs only mid-frame; any DV (or leaving the frame) clears it.
   always_comb begin
      toCnt_d = '0;
      if (inFrame && !i_Rx_DV && !toExpire) begin
         toCnt_d = toCnt_q + TO_W'(1);
      end
   end

   // Timeout counter register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         toCnt_q <= '0;
      end else begin
         toCnt_q <= toCnt_d;
      end
   end
`else
   assign toExpire = 1'b0;
`endif

   // Next-state and next-output logic; outputs are computed one cycle ahead so
   // every port comes straight from a flop.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      chk_d      = chk_q;
      wrIdx_d    = wrIdx_q;
      rdIdx_d    = rdIdx_q;
      pktData_d  = pktData_q;
      pktValid_d = pktValid_q;
      pktLast_d  = pktLast_q;
      pktLen_d   = pktLen_q;
      frameErr_d = 1'b0;
      errCode_d  = errCode_q;
      overrun_d  = 1'b0;
      bufWe      = 1'b0;
      bufRaddr   = (state_q == S_DRAIN) ? (rdIdx_q + 8'd1) : 8'd0;

      case (state_q)
         S_SYNC: begin
            if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (i_Rx_DV) begin
               if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > 8'(MAX_LEN))) begin
                  frameErr_d = 1'b1;
                  errCode_d  = ERR_LEN;
                  state_d    = S_SYNC;
               end else begin
                  len_d   = i_Rx_Byte;
                  chk_d   = i_Rx_Byte;
                  wrIdx_d = 8'd0;
                  state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (i_Rx_DV) begin
               bufWe   = 1'b1;
               chk_d   = chk_q ^ i_Rx_Byte;
               wrIdx_d = wrIdx_q + 8'd1;
               if ((wrIdx_q + 8'd1) == len_q) begin
                  state_d = S_CHK;
               end
            end
         end
         S_CHK: begin
            if (i_Rx_DV) begin
               if (i_Rx_Byte == chk_q) begin
                  state_d    = S_DRAIN;
                  rdIdx_d    = 8'd0;
                  pktValid_d = 1'b1;
                  pktData_d  = bufRdata;
                  pktLast_d  = (len_q == 8'd1);
                  pktLen_d   = len_q;
               end else begin
                  frameErr_d = 1'b1;
                  errCode_d  = ERR_CHK;
                  state_d    = S_SYNC;
               end
            end
         end
         S_DRAIN: begin
            if (i_Rx_DV) begin
               overrun_d = 1'b1;
            end
            if (pktValid_q && i_Pkt_Ready) begin
               if (pktLast_q) begin
                  pktValid_d = 1'b0;
                  pktLast_d  = 1'b0;
                  state_d    = S_SYNC;
               end else begin
                  rdIdx_d   = rdIdx_q + 8'd1;
                  pktData_d = bufRdata;
                  pktLast_d = ((rdIdx_q + 8'd1) == (len_q - 8'd1));
               end
            end
         end
         default: begin
            state_d    = S_SYNC;
            pktValid_d = 1'b0;
            pktLast_d  = 1'b0;
         end
      endcase

      if (toExpire) begin
         frameErr_d = 1'b1;
         errCode_d  = ERR_TIMEOUT;
         state_d    = S_SYNC;
      end
   end

   // State, datapath and output registers; reset discards any frame in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_SYNC;
         len_q      <= 8'd0;
         chk_q      <= 8'd0;
         wrIdx_q    <= 8'd0;
         rdIdx_q    <= 8'd0;
         pktData_q  <= 8'd0;
         pktValid_q <= 1'b0;
         pktLast_q  <= 1'b0;
         pktLen_q   <= 8'd0;
         frameErr_q <= 1'b0;
         errCode_q  <= ERR_NONE;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         chk_q      <= chk_d;
         wrIdx_q    <= wrIdx_d;
         rdIdx_q    <= rdIdx_d;
         pktData_q  <= pktData_d;
         pktValid_q <= pktValid_d;
         pktLast_q  <= pktLast_d;
         pktLen_q   <= pktLen_d;
         frameErr_q <= frameErr_d;
         errCode_q  <= errCode_d;
         overrun_q  <= overrun_d;
      end
   end

   assign o_Pkt_Data  = pktData_q;
   assign o_Pkt_Valid = pktValid_q;
   assign o_Pkt_Last  = pktLast_q;
   assign o_Pkt_Len   = pktLen_q;
   assign o_Frame_Err = frameErr_q;
   assign o_Err_Code  = errCode_q;
   assign o_Overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: good frames, backpressure, framing
// errors, sync hunt, overrun, reset mid-frame and, when UART_RX_PKT_TIMEOUT_EN
// is defined, the inter-byte timeout with TIMEOUT_CLKS = 100.
module tb_uart_rx_pkt_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [7:0] i_Rx_Byte = 8'h00;
   logic       i_Rx_DV = 1'b0;
   logic       i_Pkt_Ready = 1'b1;
   logic [7:0] o_Pkt_Data;
   logic       o_Pkt_Valid;
   logic       o_Pkt_Last;
   logic [7:0] o_Pkt_Len;
   logic       o_Frame_Err;
   logic [1:0] o_Err_Code;
   logic       o_Overrun;

   int checkCount = 0;
   int errorCount = 0;

   logic [7:0] frameQ[$];
   logic [7:0] expQ[$];

   uart_rx_pkt_ctrl #(
      .MAX_LEN      (16),
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_CLKS (100)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_Rx_Byte   (i_Rx_Byte),
      .i_Rx_DV     (i_Rx_DV),
      .o_Pkt_Data  (o_Pkt_Data),
      .o_Pkt_Valid (o_Pkt_Valid),
      .i_Pkt_Ready (i_Pkt_Ready),
      .o_Pkt_Last  (o_Pkt_Last),
      .o_Pkt_Len   (o_Pkt_Len),
      .o_Frame_Err (o_Frame_Err),
      .o_Err_Code  (o_Err_Code),
      .o_Overrun   (o_Overrun)
   );

   // Free-running 10 ns clock.
   always #5 i_clk = ~i_clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present one byte with a one-cycle DV strobe; returns 1 ns after the edge
   // that captured it, where registered responses are already visible.
   task automatic applyStimulus(input logic [7:0] b);
      i_Rx_Byte = b;
      i_Rx_DV   = 1'b1;
      @(posedge i_clk);
      #1;
      i_Rx_DV   = 1'b0;
      i_Rx_Byte = 8'h00;
   endtask

   // Send every byte currently in frameQ back to back.
   task automatic sendFrame();
      foreach (frameQ[i]) applyStimulus(frameQ[i]);
   endtask

   // Let the clock run idle for n cycles.
   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   // Drain the packet against expQ, ready either held high or toggling 1010.
   task automatic drainFrame(input bit toggle);
      int k   = 0;
      int cyc = 0;
      int n   = expQ.size();
      while ((k < n) && (cyc < 100)) begin
         i_Pkt_Ready = toggle ? ((cyc % 2) == 0) : 1'b1;
         checkOutput($sformatf("valid[%0d]", k), 32'(o_Pkt_Valid), 32'd1);
         checkOutput($sformatf("data[%0d]", k), 32'(o_Pkt_Data), 32'(expQ[k]));
         checkOutput($sformatf("last[%0d]", k), 32'(o_Pkt_Last), 32'(k == n - 1));
         checkOutput($sformatf("len[%0d]", k), 32'(o_Pkt_Len), n);
         if (i_Pkt_Ready) k++;
         @(posedge i_clk);
         #1;
         cyc++;
      end
      checkOutput("drainCount", k, n);
      checkOutput("validDrop", 32'(o_Pkt_Valid), 32'd0);
      i_Pkt_Ready = 1'b1;
   endtask

   // Check every output against its reset value.
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_valid"}, 32'(o_Pkt_Valid), 32'd0);
      checkOutput({tag, "_last"}, 32'(o_Pkt_Last), 32'd0);
      checkOutput({tag, "_err"}, 32'(o_Frame_Err), 32'd0);
      checkOutput({tag, "_ovr"}, 32'(o_Overrun), 32'd0);
      checkOutput({tag, "_code"}, 32'(o_Err_Code), 32'd0);
      checkOutput({tag, "_data"}, 32'(o_Pkt_Data), 32'd0);
      checkOutput({tag, "_plen"}, 32'(o_Pkt_Len), 32'd0);
   endtask

   // Standard good frame A5 03 11 22 33 03 with its expected payload.
   task automatic loadGoodFrame();
      frameQ = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      expQ   = {8'h11, 8'h22, 8'h33};
   endtask

   // Directed test sequence.
   initial begin
      $display("[TB] start");
      repeat (3) @(posedge i_clk);
      #1;
      checkResetOutputs("reset");
      i_rst = 1'b0;
      idleCycles(2);

      // Good frame, ready held high.
      loadGoodFrame();
      sendFrame();
      checkOutput("good_noErr", 32'(o_Frame_Err), 32'd0);
      checkOutput("good_code", 32'(o_Err_Code), 32'd0);
      drainFrame(1'b0);

      // Same frame with ready toggling.
      loadGoodFrame();
      sendFrame();
      drainFrame(1'b1);

      // Bad checksum: 02 ^ AA ^ BB = 13, frame carries 00.
      frameQ = {8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00};
      sendFrame();
      checkOutput("badChk_err", 32'(o_Frame_Err), 32'd1);
      checkOutput("badChk_code", 32'(o_Err_Code), 32'd2);
      checkOutput("badChk_valid", 32'(o_Pkt_Valid), 32'd0);
      idleCycles(1);
      checkOutput("badChk_pulse", 32'(o_Frame_Err), 32'd0);
      checkOutput("badChk_hold", 32'(o_Err_Code), 32'd2);

      // Bad lengths: zero and MAX_LEN+1.
      frameQ = {8'hA5, 8'h00};
      sendFrame();
      checkOutput("len0_err", 32'(o_Frame_Err), 32'd1);
      checkOutput("len0_code", 32'(o_Err_Code), 32'd1);
      idleCycles(1);
      frameQ = {8'hA5, 8'h11};
      sendFrame();
      checkOutput("len17_err", 32'(o_Frame_Err), 32'd1);
      checkOutput("len17_code", 32'(o_Err_Code), 32'd1);
      checkOutput("len17_valid", 32'(o_Pkt_Valid), 32'd0);
      idleCycles(1);

      // Maximum length: payload i*0x11 for i=0..15 XORs to 0, so CHK = 10.
      frameQ = {8'hA5, 8'h10};
      expQ   = {};
      for (int i = 0; i < 16; i++) begin
         frameQ.push_back(8'(i * 17));
         expQ.push_back(8'(i * 17));
      end
      frameQ.push_back(8'h10);
      sendFrame();
      checkOutput("max_noErr", 32'(o_Frame_Err), 32'd0);
      drainFrame(1'b0);

      // Single-byte payload: Last on the first and only byte.
      frameQ = {8'hA5, 8'h01, 8'h7E, 8'h7F};
      expQ   = {8'h7E};
      sendFrame();
      drainFrame(1'b0);

      // Sync hunt: garbage is dropped silently, then a good frame (CHK FD).
      frameQ = {8'h00, 8'hFF, 8'h5A};
      foreach (frameQ[i]) begin
         applyStimulus(frameQ[i]);
         checkOutput($sformatf("garbage_err[%0d]", i), 32'(o_Frame_Err), 32'd0);
         checkOutput($sformatf("garbage_valid[%0d]", i), 32'(o_Pkt_Valid), 32'd0);
      end
      frameQ = {8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
      expQ   = {8'hC3, 8'h3C};
      sendFrame();
      drainFrame(1'b0);

      // Overrun during a stalled drain, then a back-to-back frame.
      i_Pkt_Ready = 1'b0;
      frameQ = {8'hA5, 8'h02, 8'h12, 8'h34, 8'h24};
      expQ   = {8'h12, 8'h34};
      sendFrame();
      checkOutput("stall_valid", 32'(o_Pkt_Valid), 32'd1);
      applyStimulus(8'hA5);
      checkOutput("ovr_pulse", 32'(o_Overrun), 32'd1);
      checkOutput("ovr_data", 32'(o_Pkt_Data), 32'h12);
      checkOutput("ovr_valid", 32'(o_Pkt_Valid), 32'd1);
      idleCycles(1);
      checkOutput("ovr_clear", 32'(o_Overrun), 32'd0);
      checkOutput("ovr_noErr", 32'(o_Frame_Err), 32'd0);
      drainFrame(1'b0);
      frameQ = {8'hA5, 8'h01, 8'h7E, 8'h7F};
      expQ   = {8'h7E};
      sendFrame();
      drainFrame(1'b0);

`ifdef UART_RX_PKT_TIMEOUT_EN
      // Timeout: error appears after exactly 100 idle clocks.
      frameQ = {8'hA5, 8'h02, 8'h11};
      sendFrame();
      idleCycles(99);
      checkOutput("to_early", 32'(o_Frame_Err), 32'd0);
      idleCycles(1);
      checkOutput("to_err", 32'(o_Frame_Err), 32'd1);
      checkOutput("to_code", 32'(o_Err_Code), 32'd3);
      loadGoodFrame();
      sendFrame();
      drainFrame(1'b0);
`endif

      // Make error code nonzero so the reset checks are meaningful.
      frameQ = {8'hA5, 8'h00};
      sendFrame();
      checkOutput("preRst_code", 32'(o_Err_Code), 32'd1);

      // Reset mid-payload.
      frameQ = {8'hA5, 8'h03, 8'h11};
      sendFrame();
      #2;
      i_rst = 1'b1;
      #1;
      checkResetOutputs("rstPayload");
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      loadGoodFrame();
      sendFrame();
      drainFrame(1'b0);

      // Reset mid-drain with the consumer stalled.
      i_Pkt_Ready = 1'b0;
      frameQ = {8'hA5, 8'h01, 8'h7E, 8'h7F};
      sendFrame();
      checkOutput("preRstDrain_valid", 32'(o_Pkt_Valid), 32'd1);
      checkOutput("preRstDrain_last", 32'(o_Pkt_Last), 32'd1);
      #2;
      i_rst = 1'b1;
      #1;
      checkResetOutputs("rstDrain");
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      i_Pkt_Ready = 1'b1;
      loadGoodFrame();
      sendFrame();
      drainFrame(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
